// File: rtl/uart_alu_pkg.sv
// Shared opcode constants and controller state encoding for the UART-fed ALU.
package uart_alu_pkg;

    localparam int unsigned OP_W = 8;

    localparam logic [OP_W-1:0] OP_ADD = 8'h20;
    localparam logic [OP_W-1:0] OP_SUB = 8'h22;
    localparam logic [OP_W-1:0] OP_AND = 8'h24;
    localparam logic [OP_W-1:0] OP_OR  = 8'h25;
    localparam logic [OP_W-1:0] OP_XOR = 8'h26;
    localparam logic [OP_W-1:0] OP_NOR = 8'h27;
    localparam logic [OP_W-1:0] OP_SRL = 8'h02;
    localparam logic [OP_W-1:0] OP_SRA = 8'h03;

    typedef enum logic [2:0] {
        ST_WAIT_A  = 3'd0,
        ST_WAIT_B  = 3'd1,
        ST_WAIT_OP = 3'd2,
        ST_EXEC    = 3'd3,
        ST_SEND    = 3'd4,
        ST_WAIT_TX = 3'd5
    } state_e;

    // States in which the controller refuses new bytes.
    function automatic logic is_busy(input state_e s);
        return (s == ST_EXEC) || (s == ST_SEND) || (s == ST_WAIT_TX);
    endfunction

endpackage

// File: rtl/uart_alu_interface_alu.sv
// Combinational ALU: wrap-around add/sub, bitwise ops and logical/arithmetic right shifts.
module alu
    import uart_alu_pkg::*;
#(
    parameter int unsigned DATA_BITS = 8
) (
    input  logic [DATA_BITS-1:0] a,
    input  logic [DATA_BITS-1:0] b,
    input  logic [DATA_BITS-1:0] op,
    output logic [DATA_BITS-1:0] y,
    output logic                 invalid
);

    logic shift_over;

    // A shift of DATA_BITS or more would leave no original bit in place.
    assign shift_over = (b >= DATA_BITS'(DATA_BITS));

    always_comb begin
        y       = '0;
        invalid = 1'b0;
        case (op)
            DATA_BITS'(OP_ADD): y = a + b;
            DATA_BITS'(OP_SUB): y = a - b;
            DATA_BITS'(OP_AND): y = a & b;
            DATA_BITS'(OP_OR):  y = a | b;
            DATA_BITS'(OP_XOR): y = a ^ b;
            DATA_BITS'(OP_NOR): y = ~(a | b);
            DATA_BITS'(OP_SRL): y = shift_over ? '0 : (a >> b);
            DATA_BITS'(OP_SRA): y = shift_over ? {DATA_BITS{a[DATA_BITS-1]}}
                                               : DATA_BITS'($signed(a) >>> b);
            default:            invalid = 1'b1;
        endcase
    end

endmodule

// File: rtl/uart_alu_interface.sv
// Collects A, B and opcode bytes from a UART receiver, evaluates them and hands the result to the transmitter.
module uart_alu_interface
    import uart_alu_pkg::*;
#(
    parameter int unsigned DATA_BITS      = 8,
    parameter int unsigned TIMEOUT_CYCLES = 100000000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] rx_data,
    input  logic                 rx_done,
    input  logic                 tx_done,
    output logic                 tx_start,
    output logic [DATA_BITS-1:0] tx_data,
    output logic [DATA_BITS-1:0] result,
    output logic                 busy,
    output logic                 bad_op,
    output logic                 timeout
);

    localparam int unsigned    CNT_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam bit             TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    state_e               state_q, state_d;
    logic [DATA_BITS-1:0] reg_a_q, reg_a_d;
    logic [DATA_BITS-1:0] reg_b_q, reg_b_d;
    logic [DATA_BITS-1:0] reg_op_q, reg_op_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [DATA_BITS-1:0] result_d, tx_data_d;
    logic                 tx_start_d, busy_d, bad_op_d, timeout_d;

    logic [DATA_BITS-1:0] alu_op;
    logic [DATA_BITS-1:0] alu_y;
    logic                 alu_invalid;
    logic                 cnt_expired;

    // While the opcode is arriving the ALU looks at it directly so bad_op can line up with EXEC.
    assign alu_op      = (state_q == ST_WAIT_OP) ? rx_data : reg_op_q;
    assign cnt_expired = TIMEOUT_EN && (cnt_q == CNT_LAST);

    alu #(
        .DATA_BITS (DATA_BITS)
    ) u_alu (
        .a       (reg_a_q),
        .b       (reg_b_q),
        .op      (alu_op),
        .y       (alu_y),
        .invalid (alu_invalid)
    );

    always_comb begin
        state_d    = state_q;
        reg_a_d    = reg_a_q;
        reg_b_d    = reg_b_q;
        reg_op_d   = reg_op_q;
        cnt_d      = cnt_q;
        result_d   = result;
        tx_data_d  = tx_data;
        tx_start_d = 1'b0;
        bad_op_d   = 1'b0;
        timeout_d  = 1'b0;

        case (state_q)
            ST_WAIT_A: begin
                cnt_d = '0;
                if (rx_done) begin
                    reg_a_d = rx_data;
                    state_d = ST_WAIT_B;
                end
            end
            ST_WAIT_B, ST_WAIT_OP: begin
                if (rx_done) begin
                    cnt_d = '0;
                    if (state_q == ST_WAIT_B) begin
                        reg_b_d = rx_data;
                        state_d = ST_WAIT_OP;
                    end else begin
                        reg_op_d = rx_data;
                        bad_op_d = alu_invalid;
                        state_d  = ST_EXEC;
                    end
                end else if (cnt_expired) begin
                    // Stalled sender: drop the partial operand set and resynchronise on a fresh A.
                    timeout_d = 1'b1;
                    reg_a_d   = '0;
                    reg_b_d   = '0;
                    cnt_d     = '0;
                    state_d   = ST_WAIT_A;
                end else if (TIMEOUT_EN) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_EXEC: begin
                result_d   = alu_y;
                tx_data_d  = alu_y;
                tx_start_d = 1'b1;
                state_d    = ST_SEND;
            end
            ST_SEND: begin
                state_d = ST_WAIT_TX;
            end
            ST_WAIT_TX: begin
                if (tx_done) begin
                    state_d = ST_WAIT_A;
                end
            end
            default: begin
                state_d = ST_WAIT_A;
            end
        endcase

        busy_d = is_busy(state_d);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_WAIT_A;
            reg_a_q  <= '0;
            reg_b_q  <= '0;
            reg_op_q <= '0;
            cnt_q    <= '0;
            result   <= '0;
            tx_data  <= '0;
            tx_start <= 1'b0;
            busy     <= 1'b0;
            bad_op   <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            state_q  <= state_d;
            reg_a_q  <= reg_a_d;
            reg_b_q  <= reg_b_d;
            reg_op_q <= reg_op_d;
            cnt_q    <= cnt_d;
            result   <= result_d;
            tx_data  <= tx_data_d;
            tx_start <= tx_start_d;
            busy     <= busy_d;
            bad_op   <= bad_op_d;
            timeout  <= timeout_d;
        end
    end

endmodule

// File: tb/tb_uart_alu_interface.sv
// Directed bench for uart_alu_interface: opcode results, handshake timing, timeout and reset abort.
module tb_uart_alu_interface;

    localparam int unsigned DW = 8;
    localparam int unsigned TO = 50;

    logic          clk;
    logic          reset;
    logic [DW-1:0] rx_data;
    logic          rx_done;
    logic          tx_done;
    logic          tx_start;
    logic [DW-1:0] tx_data;
    logic [DW-1:0] result;
    logic          busy;
    logic          bad_op;
    logic          timeout;

    int n_cmp = 0;
    int n_err = 0;
    int n_tx_start = 0;
    int n_timeout = 0;
    int exp_starts = 0;

    uart_alu_interface #(
        .DATA_BITS      (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rx_data  (rx_data),
        .rx_done  (rx_done),
        .tx_done  (tx_done),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .result   (result),
        .busy     (busy),
        .bad_op   (bad_op),
        .timeout  (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tx_start) n_tx_start++;
        if (timeout)  n_timeout++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [DW-1:0] b);
        @(negedge clk);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    // Delivers the opcode and follows EXEC, SEND and entry into WAIT_TX.
    task automatic send_op(input logic [DW-1:0] op, input logic [DW-1:0] exp,
                           input logic exp_bad, input string tag);
        @(negedge clk);
        rx_data = op;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
        check({tag, ".exec_bad_op"}, 32'(bad_op), 32'(exp_bad));
        check({tag, ".exec_busy"}, 32'(busy), 32'd1);
        check({tag, ".exec_no_start"}, 32'(tx_start), 32'd0);
        @(negedge clk);
        check({tag, ".send_start"}, 32'(tx_start), 32'd1);
        check({tag, ".send_tx_data"}, 32'(tx_data), 32'(exp));
        check({tag, ".send_result"}, 32'(result), 32'(exp));
        check({tag, ".send_bad_op_low"}, 32'(bad_op), 32'd0);
        exp_starts++;
        @(negedge clk);
        check({tag, ".wait_tx_start_low"}, 32'(tx_start), 32'd0);
    endtask

    task automatic start_op(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] op,
                            input logic [DW-1:0] exp, input logic exp_bad, input string tag);
        send_byte(a);
        send_byte(b);
        send_op(op, exp, exp_bad, tag);
    endtask

    task automatic end_op(input logic [DW-1:0] exp, input string tag);
        @(negedge clk);
        check({tag, ".held_tx_data"}, 32'(tx_data), 32'(exp));
        check({tag, ".held_busy"}, 32'(busy), 32'd1);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        check({tag, ".idle_busy"}, 32'(busy), 32'd0);
        check({tag, ".idle_result"}, 32'(result), 32'(exp));
        check({tag, ".start_count"}, 32'(n_tx_start), 32'(exp_starts));
    endtask

    task automatic run_op(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] op,
                          input logic [DW-1:0] exp, input logic exp_bad, input string tag);
        start_op(a, b, op, exp, exp_bad, tag);
        end_op(exp, tag);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".tx_start"}, 32'(tx_start), 32'd0);
        check({tag, ".tx_data"}, 32'(tx_data), 32'd0);
        check({tag, ".result"}, 32'(result), 32'd0);
        check({tag, ".busy"}, 32'(busy), 32'd0);
        check({tag, ".bad_op"}, 32'(bad_op), 32'd0);
        check({tag, ".timeout"}, 32'(timeout), 32'd0);
    endtask

    initial begin
        int t0;
        reset   = 1'b0;
        rx_data = '0;
        rx_done = 1'b0;
        tx_done = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b1;
        repeat (2) @(negedge clk);

        run_op(8'h05, 8'h03, 8'h20, 8'h08, 1'b0, "add");
        run_op(8'h03, 8'h05, 8'h22, 8'hFE, 1'b0, "sub_wrap");
        run_op(8'h0F, 8'hF0, 8'h27, 8'h00, 1'b0, "nor");
        run_op(8'hF0, 8'h3C, 8'h24, 8'h30, 1'b0, "and");
        run_op(8'h0F, 8'h30, 8'h25, 8'h3F, 1'b0, "or");
        run_op(8'hFF, 8'h0F, 8'h26, 8'hF0, 1'b0, "xor");
        run_op(8'h80, 8'h02, 8'h03, 8'hE0, 1'b0, "sra2");
        run_op(8'h80, 8'h02, 8'h02, 8'h20, 1'b0, "srl2");
        run_op(8'h80, 8'h09, 8'h03, 8'hFF, 1'b0, "sra_over");
        run_op(8'h80, 8'h09, 8'h02, 8'h00, 1'b0, "srl_over");
        run_op(8'h12, 8'h34, 8'hFF, 8'h00, 1'b1, "bad_op");

        // Bytes arriving while the transmitter is busy, including one coincident with tx_done.
        start_op(8'h05, 8'h03, 8'h20, 8'h08, 1'b0, "ign");
        send_byte(8'h44);
        @(negedge clk);
        rx_data = 8'h55;
        rx_done = 1'b1;
        tx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
        tx_done = 1'b0;
        check("ign.idle_busy", 32'(busy), 32'd0);
        run_op(8'h06, 8'h07, 8'h20, 8'h0D, 1'b0, "after_ign");

        // Stall after A, then after B: each must time out exactly once.
        t0 = n_timeout;
        send_byte(8'h09);
        repeat (60) @(negedge clk);
        check("to_b.count", 32'(n_timeout - t0), 32'd1);
        check("to_b.pulse_ended", 32'(timeout), 32'd0);
        run_op(8'h01, 8'h01, 8'h20, 8'h02, 1'b0, "after_to_b");
        t0 = n_timeout;
        send_byte(8'h09);
        send_byte(8'h01);
        repeat (60) @(negedge clk);
        check("to_op.count", 32'(n_timeout - t0), 32'd1);
        run_op(8'h01, 8'h01, 8'h20, 8'h02, 1'b0, "after_to_op");

        // B lands in the 50th idle cycle: accepted, no timeout.
        t0 = n_timeout;
        send_byte(8'h10);
        repeat (48) @(negedge clk);
        send_byte(8'h04);
        send_op(8'h20, 8'h14, 1'b0, "edge");
        end_op(8'h14, "edge");
        check("edge.no_timeout", 32'(n_timeout - t0), 32'd0);

        // Reset while waiting on the transmitter.
        start_op(8'h22, 8'h11, 8'h20, 8'h33, 1'b0, "rst");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_all_zero("rst_wait_tx");
        @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        check("rst.no_extra_start", 32'(n_tx_start), 32'(exp_starts));
        check("rst.idle_busy", 32'(busy), 32'd0);
        run_op(8'h07, 8'h02, 8'h22, 8'h05, 1'b0, "after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_alu_interface.md
UART_ALU_INTERFACE -- requirements
Module: uart_alu_interface

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, operand/result/byte width.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 100000000, inter-byte timeout in clk cycles; 0 disables timeout.
REQ-003 SHALL have port clk  input  1  single system clock, rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port rx_data  input  DATA_BITS  received byte, valid when rx_done=1.
REQ-006 SHALL have port rx_done  input  1  one-cycle pulse per received byte.
REQ-007 SHALL have port tx_done  input  1  one-cycle pulse when transmitter finishes a byte.
REQ-008 SHALL have port tx_start  output  1  one-cycle request to transmit tx_data.
REQ-009 SHALL have port tx_data  output  DATA_BITS  byte to transmit.
REQ-010 SHALL have port result  output  DATA_BITS  last computed result, held.
REQ-011 SHALL have port busy  output  1  high in EXEC, SEND and WAIT_TX.
REQ-012 SHALL have port bad_op  output  1  one-cycle pulse on unsupported opcode.
REQ-013 SHALL have port timeout  output  1  one-cycle pulse on inter-byte timeout.

Function
REQ-014 SHALL implement FSM states WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND, WAIT_TX.
REQ-015 SHALL, in WAIT_A/WAIT_B/WAIT_OP, on rx_done capture rx_data into reg_a/reg_b/reg_op and advance to the next state.
REQ-016 SHALL, in EXEC (one cycle), register the ALU output into result and raise bad_op if the opcode is unsupported, then go to SEND.
REQ-017 SHALL, in SEND, assert tx_start for exactly one cycle with tx_data=result, then go to WAIT_TX.
REQ-018 SHALL hold tx_data stable from SEND until tx_done, then return to WAIT_A.
REQ-019 SHALL produce tx_start exactly 2 cycles after the rx_done that delivers the opcode.
REQ-020 SHALL ignore rx_done in EXEC, SEND and WAIT_TX; a byte arriving with tx_done in WAIT_TX is dropped.
REQ-021 SHALL ignore tx_done outside WAIT_TX.
REQ-022 SHALL support opcodes ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, XOR 0x26, NOR 0x27, SRL 0x02, SRA 0x03.
REQ-023 SHALL compute ADD/SUB modulo 2^DATA_BITS with no carry/overflow output.
REQ-024 SHALL use reg_b as an unsigned shift amount; shift >= DATA_BITS gives 0 for SRL and sign-fill for SRA.
REQ-025 SHALL send result 0 for an unsupported opcode, together with a bad_op pulse.
REQ-026 SHALL count cycles in WAIT_B/WAIT_OP, clearing the count on each accepted byte; at TIMEOUT_CYCLES, pulse timeout and return to WAIT_A, discarding captured operands.
REQ-027 SHALL give an rx_done in the same cycle the count reaches TIMEOUT_CYCLES priority: accept the byte, no timeout.

Reset
REQ-028 SHALL, while reset=0, force state WAIT_A, and reg_a, reg_b, reg_op, result, tx_data, the timeout counter, tx_start, busy, bad_op and timeout all to 0.
REQ-029 SHALL abort any in-progress operation on reset assertion without emitting tx_start.

Structure
REQ-030 SHALL place opcode constants and state encodings in shared package uart_alu_pkg.
REQ-031 SHALL instantiate the arithmetic as combinational sub-module alu (DATA_BITS parameter; inputs a, b, op; outputs y, invalid).

Verification
REQ-032 SHALL verify A=0x05, B=0x03, OP=0x20 -> single tx_start 2 cycles after the opcode, tx_data=0x08, result=0x08.
REQ-033 SHALL verify A=0x03, B=0x05, OP=0x22 -> tx_data=0xFE; A=0x0F, B=0xF0, OP=0x27 -> 0x00.
REQ-034 SHALL verify A=0x80, B=0x02: OP=0x03 -> 0xE0, OP=0x02 -> 0x20; B=0x09 with OP=0x03 -> 0xFF.
REQ-035 SHALL verify OP=0xFF -> tx_data=0x00 with a bad_op pulse coincident with EXEC.
REQ-036 SHALL verify (TIMEOUT_CYCLES=50) A byte then a 50-cycle gap -> timeout pulse; the next three bytes 0x01, 0x01, 0x20 -> tx_data=0x02.
REQ-037 SHALL verify an rx_done during WAIT_TX is ignored, and reset=0 during WAIT_TX -> all outputs 0, no tx_start, next operation correct.
